// File: rtl/gcd_engine.sv
// Iterative subtractive-Euclid GCD unit with go/busy/done handshake, one subtraction per clock.
// Optional feature macro: GCD_CYCLE_COUNT_EN adds a saturating count of calc cycles on 'cycles'.
module gcd_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             go,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic [WIDTH-1:0] cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [WIDTH-1:0] gcd_reg, gcd_next;
  logic             done_reg, done_next;
  logic             finish;

`ifdef GCD_CYCLE_COUNT_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] cycles_reg, cycles_next;
  logic [WIDTH-1:0] cnt_inc;

  // Saturating +1; the same value feeds both the counter and the reported total.
  assign cnt_inc = (cnt_reg == ALL_ONES) ? cnt_reg : cnt_reg + 1'b1;
`endif

  // A zero operand or equal operands both end the computation on this edge.
  assign finish = (x_reg == '0) || (y_reg == '0) || (x_reg == y_reg);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      gcd_reg    <= '0;
      done_reg   <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_reg    <= '0;
      cycles_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      gcd_reg    <= gcd_next;
      done_reg   <= done_next;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_reg    <= cnt_next;
      cycles_reg <= cycles_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    gcd_next    = gcd_reg;
    done_next   = 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
    cnt_next    = cnt_reg;
    cycles_next = cycles_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (go) begin
          x_next     = xin;
          y_next     = yin;
          state_next = CALC;
`ifdef GCD_CYCLE_COUNT_EN
          cnt_next   = '0;
`endif
        end
      end
      CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_next = cnt_inc;
`endif
        if (finish) begin
          // x|y covers the zero-operand case and equals x when x==y.
          gcd_next   = x_reg | y_reg;
          done_next  = 1'b1;
          state_next = IDLE;
`ifdef GCD_CYCLE_COUNT_EN
          cycles_next = cnt_inc;
`endif
        end else if (x_reg > y_reg) begin
          x_next = x_reg - y_reg;
        end else begin
          y_next = y_reg - x_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == CALC);
  assign done = done_reg;
  assign gcd  = gcd_reg;
`ifdef GCD_CYCLE_COUNT_EN
  assign cycles = cycles_reg;
`else
  assign cycles = '0;
`endif

endmodule
